processor_stage2_gen: RTL and testbench

- Parametrised successor of the operand-fetch / memory-access stage of the in-order pipeline.
- Sits between the fetch stage (stage 1) and the ALU stage (stage 3).
- Reads the register file, does the store / call-push memory access and resolves branches, calls and returns.
- New relative to the previous generation: parametrised register count, a valid/ready handshake with stall propagation, a counted wait with timeout, and resumable halt.

---
 rtl/processor_pkg.sv | 45 ++++
 rtl/processor_stage2_gen_if.sv | 65 ++++++
 rtl/if_control.sv | 39 +++
 rtl/processor_stage2_gen.sv | 204 ++++++++++++++++++++
 tb/tb_processor_stage2_gen.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/processor_pkg.sv
// processor_pkg
// Shared definitions for the operand-fetch / memory-access stage (stage 2)
// and its helpers: opcode constants, the stage-2 FSM state encoding and the
// condition encodings evaluated by if_control.
// No ports (package).

package processor_pkg;

  localparam int OPCODE_BITS = 4;
  localparam int IF_OP_BITS  = 3;

  // Opcode constants (top 4 bits of the instruction word)
  localparam logic [OPCODE_BITS-1:0] OP_NOP             = 4'h0;
  localparam logic [OPCODE_BITS-1:0] OP_ADD             = 4'h1;
  localparam logic [OPCODE_BITS-1:0] OP_SUB             = 4'h2;
  localparam logic [OPCODE_BITS-1:0] OP_AND             = 4'h3;
  localparam logic [OPCODE_BITS-1:0] OP_OR              = 4'h4;
  localparam logic [OPCODE_BITS-1:0] OP_LOAD_IMM        = 4'h5;
  localparam logic [OPCODE_BITS-1:0] OP_READ_FROM_MEMORY = 4'h6;
  localparam logic [OPCODE_BITS-1:0] OP_WRITE_TO_MEMORY = 4'h8;
  localparam logic [OPCODE_BITS-1:0] OP_IF              = 4'h9;
  localparam logic [OPCODE_BITS-1:0] OP_CALL_IMM14      = 4'hA;
  localparam logic [OPCODE_BITS-1:0] OP_RETURN          = 4'hB;
  localparam logic [OPCODE_BITS-1:0] OP_WAIT            = 4'hC;

  // Stage-2 FSM states
  typedef enum logic [1:0] {
    ST_RUN,
    ST_WAIT_CNT,
    ST_HALT
  } stage2_state_t;

  // Condition encodings for OP_IF; carried in the ry field of the word
  typedef enum logic [IF_OP_BITS-1:0] {
    IF_ALWAYS   = 3'd0,
    IF_ZERO     = 3'd1,
    IF_NOT_ZERO = 3'd2,
    IF_NEG      = 3'd3,
    IF_POS      = 3'd4,
    IF_NOT_NEG  = 3'd5,
    IF_NOT_POS  = 3'd6,
    IF_NEVER    = 3'd7
  } if_op_t;

endpackage

// File: rtl/processor_stage2_gen_if.sv
// processor_stage2_gen_if
// Bundles every stage-2 signal except clock and reset: the stage-1 handshake,
// register-file read/writeback ports, memory write port, stage-3 handshake
// and results, and the wait/halt control.
// Modports:
//   master - the stage itself (drives memory/regfile addresses and results)
//   slave  - the surrounding pipeline (drives instruction, regfile data,
//            writeback, out_ready and wait_resume)

interface processor_stage2_gen_if #(
  parameter int ADDR_SIZE     = 18,
  parameter int WORD_SIZE     = 18,
  parameter int REG_ADDR_BITS = 3
);

  logic                     in_valid;
  logic                     in_ready;
  logic [ADDR_SIZE-1:0]     ip;
  logic [ADDR_SIZE-1:0]     ip_plus_one;
  logic [WORD_SIZE-1:0]     code_word;
  logic [ADDR_SIZE-1:0]     memory_addr;
  logic                     memory_write_enable;
  logic [WORD_SIZE-1:0]     memory_in;
  logic [REG_ADDR_BITS-1:0] reg_read_addr0;
  logic [REG_ADDR_BITS-1:0] reg_read_addr1;
  logic [WORD_SIZE-1:0]     reg_read_data0;
  logic [WORD_SIZE-1:0]     reg_read_data1;
  logic                     writeback_reg_write_enable;
  logic [REG_ADDR_BITS-1:0] writeback_reg_write_addr;
  logic [WORD_SIZE-1:0]     writeback_reg_write_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [WORD_SIZE-1:0]     alu_data0_out;
  logic [WORD_SIZE-1:0]     alu_data1_out;
  logic [WORD_SIZE-1:0]     code_word_out;
  logic [ADDR_SIZE-1:0]     data1_plus_imm8_out;
  logic [ADDR_SIZE-1:0]     ip_to_call;
  logic                     call_performed;
  logic                     return_performed;
  logic                     waiting_global;
  logic                     wait_resume;

  modport master (
    input  in_valid, ip, ip_plus_one, code_word,
           reg_read_data0, reg_read_data1,
           writeback_reg_write_enable, writeback_reg_write_addr,
           writeback_reg_write_data, out_ready, wait_resume,
    output in_ready, memory_addr, memory_write_enable, memory_in,
           reg_read_addr0, reg_read_addr1, out_valid,
           alu_data0_out, alu_data1_out, code_word_out, data1_plus_imm8_out,
           ip_to_call, call_performed, return_performed, waiting_global
  );

  modport slave (
    output in_valid, ip, ip_plus_one, code_word,
           reg_read_data0, reg_read_data1,
           writeback_reg_write_enable, writeback_reg_write_addr,
           writeback_reg_write_data, out_ready, wait_resume,
    input  in_ready, memory_addr, memory_write_enable, memory_in,
           reg_read_addr0, reg_read_addr1, out_valid,
           alu_data0_out, alu_data1_out, code_word_out, data1_plus_imm8_out,
           ip_to_call, call_performed, return_performed, waiting_global
  );

endinterface

// File: rtl/if_control.sv
// if_control
// Evaluates a branch condition on a register value.
// Ports:
//   data_i         - operand (two's complement)
//   if_operation_i - condition encoding
//   if_ok_o        - condition holds

module if_control
  import processor_pkg::*;
#(
  parameter int WORD_SIZE = 18
) (
  input  logic [WORD_SIZE-1:0] data_i,
  input  if_op_t               if_operation_i,
  output logic                 if_ok_o
);

  logic isZero;
  logic isNeg;

  assign isZero = (data_i == '0);
  assign isNeg  = data_i[WORD_SIZE-1];

  // Signed comparisons against zero, derived from the zero and sign flags
  always_comb begin
    if_ok_o = 1'b0;
    case (if_operation_i)
      IF_ALWAYS:   if_ok_o = 1'b1;
      IF_ZERO:     if_ok_o = isZero;
      IF_NOT_ZERO: if_ok_o = !isZero;
      IF_NEG:      if_ok_o = isNeg;
      IF_POS:      if_ok_o = !isNeg && !isZero;
      IF_NOT_NEG:  if_ok_o = !isNeg;
      IF_NOT_POS:  if_ok_o = isNeg || isZero;
      default:     if_ok_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/processor_stage2_gen.sv
// processor_stage2_gen
// Operand-fetch / memory-access stage between fetch (stage 1) and ALU
// (stage 3). Reads the register file with writeback bypass, performs the
// store and call-push memory writes, resolves branches/calls/returns,
// and implements counted waits and resumable halt.
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous, active-low reset
//   bus   - processor_stage2_gen_if.master (all other signals)
// Optional feature macro PROCESSOR_DEBUG_INTERFACE_EN adds:
//   debug_get_param (in), debug_reg_addr (in), debug_data_out (out)
// WORD_SIZE must be >= 4 + 2*REG_ADDR_BITS + 8.

module processor_stage2_gen
  import processor_pkg::*;
#(
  parameter int ADDR_SIZE     = 18,
  parameter int WORD_SIZE     = 18,
  parameter int REG_ADDR_BITS = 3
) (
  input  logic                     clock,
  input  logic                     reset,
`ifdef PROCESSOR_DEBUG_INTERFACE_EN
  input  logic                     debug_get_param,
  input  logic [REG_ADDR_BITS:0]   debug_reg_addr,
  output logic [WORD_SIZE-1:0]     debug_data_out,
`endif
  processor_stage2_gen_if.master   bus
);

  localparam int RX_MSB = WORD_SIZE - OPCODE_BITS - 1;
  localparam int RY_MSB = RX_MSB - REG_ADDR_BITS;

  logic [OPCODE_BITS-1:0]   opcode;
  logic [REG_ADDR_BITS-1:0] rx, ry, regAddr0, regAddr1;
  logic [7:0]               imm8;
  logic [ADDR_SIZE-1:0]     imm14, imm8Sext, data1PlusImm8;
  logic [WORD_SIZE-1:0]     data0, data1;
  logic                     ifOk, branchTaken;
  logic                     stall, inReady, accept;

  stage2_state_t            state_q, state_d;
  logic [7:0]               waitCnt_q, waitCnt_d;
  logic                     outValid_q, outValid_d;
  logic                     returnPerf_q, returnPerf_d;
  logic [WORD_SIZE-1:0]     aluData0_q, aluData0_d;
  logic [WORD_SIZE-1:0]     aluData1_q, aluData1_d;
  logic [WORD_SIZE-1:0]     codeWord_q, codeWord_d;
  logic [ADDR_SIZE-1:0]     d1PlusImm8_q, d1PlusImm8_d;

  assign opcode   = bus.code_word[WORD_SIZE-1 -: OPCODE_BITS];
  assign rx       = bus.code_word[RX_MSB -: REG_ADDR_BITS];
  assign ry       = bus.code_word[RY_MSB -: REG_ADDR_BITS];
  assign imm8     = bus.code_word[7:0];
  assign imm14    = {{OPCODE_BITS{1'b0}}, bus.code_word[ADDR_SIZE-OPCODE_BITS-1:0]};
  assign imm8Sext = {{(ADDR_SIZE-8){imm8[7]}}, imm8};

  // Port 0 reads rx, or the debug-selected register while debug is active
  always_comb begin
    regAddr0 = rx;
`ifdef PROCESSOR_DEBUG_INTERFACE_EN
    if (debug_get_param) regAddr0 = debug_reg_addr[REG_ADDR_BITS-1:0];
`endif
  end

  // A call pushes the return address through the stack pointer (top register)
  assign regAddr1 = (opcode == OP_CALL_IMM14) ? '1 : ry;
  assign bus.reg_read_addr0 = regAddr0;
  assign bus.reg_read_addr1 = regAddr1;

  // A writeback landing this cycle is newer than the register file contents
  assign data0 = (bus.writeback_reg_write_enable && bus.writeback_reg_write_addr == regAddr0)
                 ? bus.writeback_reg_write_data : bus.reg_read_data0;
  assign data1 = (bus.writeback_reg_write_enable && bus.writeback_reg_write_addr == regAddr1)
                 ? bus.writeback_reg_write_data : bus.reg_read_data1;

  assign data1PlusImm8 = ADDR_SIZE'(data1) + imm8Sext;

  if_control #(
    .WORD_SIZE(WORD_SIZE)
  ) u_if_control (
    .data_i         (data0),
    .if_operation_i (if_op_t'(IF_OP_BITS'(ry))),
    .if_ok_o        (ifOk)
  );

  assign branchTaken = (opcode == OP_IF) && ifOk;

  // Handshake: a held result blocks new words, as does any wait state
  assign stall = outValid_q && !bus.out_ready;
  always_comb begin
    inReady = !stall && (state_q == ST_RUN);
`ifdef PROCESSOR_DEBUG_INTERFACE_EN
    if (debug_get_param) inReady = 1'b0;
`endif
  end
  assign accept       = bus.in_valid && inReady;
  assign bus.in_ready = inReady;

`ifdef PROCESSOR_DEBUG_INTERFACE_EN
  // MSB of the debug address selects the current instruction address
  assign debug_data_out = debug_reg_addr[REG_ADDR_BITS]
                          ? WORD_SIZE'(bus.ip - ADDR_SIZE'(1)) : bus.reg_read_data0;
`endif

  // Memory and call side effects; address/data muxing is unconditional,
  // only the strobes are qualified by accept
  always_comb begin
    bus.memory_write_enable = 1'b0;
    bus.memory_addr         = data1PlusImm8;
    bus.memory_in           = data0;
    bus.call_performed      = 1'b0;
    bus.ip_to_call          = bus.ip + imm8Sext;
    case (opcode)
      OP_WRITE_TO_MEMORY: bus.memory_write_enable = accept;
      OP_IF:              bus.call_performed = accept && ifOk;
      OP_CALL_IMM14: begin
        bus.memory_write_enable = accept;
        bus.memory_addr         = ADDR_SIZE'(data1);
        bus.memory_in           = WORD_SIZE'(bus.ip_plus_one);
        bus.call_performed      = accept;
        bus.ip_to_call          = imm14;
      end
      default: ;
    endcase
  end

  // Wait FSM: a counted wait stalls exactly imm8 cycles; imm8 == 0 halts
  // until wait_resume
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    case (state_q)
      ST_RUN: begin
        if (accept && opcode == OP_WAIT) begin
          if (imm8 != 8'd0) begin
            state_d   = ST_WAIT_CNT;
            waitCnt_d = imm8;
          end else begin
            state_d = ST_HALT;
          end
        end
      end
      ST_WAIT_CNT: begin
        waitCnt_d = waitCnt_q - 8'd1;
        if (waitCnt_q == 8'd1) state_d = ST_RUN;
      end
      ST_HALT: if (bus.wait_resume) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // Output registers: load on accept, hold on stall, otherwise drain
  always_comb begin
    outValid_d   = outValid_q;
    returnPerf_d = 1'b0;
    aluData0_d   = aluData0_q;
    aluData1_d   = aluData1_q;
    codeWord_d   = codeWord_q;
    d1PlusImm8_d = d1PlusImm8_q;
    if (accept) begin
      outValid_d   = (opcode != OP_WAIT);
      returnPerf_d = (opcode == OP_RETURN);
      aluData0_d   = data0;
      aluData1_d   = branchTaken ? WORD_SIZE'(bus.ip) : data1;
      codeWord_d   = bus.code_word;
      d1PlusImm8_d = data1PlusImm8;
    end else if (!stall) begin
      outValid_d = 1'b0;
    end
  end

  // State and output registers; reset aborts any wait in progress
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_RUN;
      waitCnt_q    <= '0;
      outValid_q   <= 1'b0;
      returnPerf_q <= 1'b0;
      aluData0_q   <= '0;
      aluData1_q   <= '0;
      codeWord_q   <= '0;
      d1PlusImm8_q <= '0;
    end else begin
      state_q      <= state_d;
      waitCnt_q    <= waitCnt_d;
      outValid_q   <= outValid_d;
      returnPerf_q <= returnPerf_d;
      aluData0_q   <= aluData0_d;
      aluData1_q   <= aluData1_d;
      codeWord_q   <= codeWord_d;
      d1PlusImm8_q <= d1PlusImm8_d;
    end
  end

  assign bus.out_valid           = outValid_q;
  assign bus.return_performed    = returnPerf_q;
  assign bus.alu_data0_out       = aluData0_q;
  assign bus.alu_data1_out       = aluData1_q;
  assign bus.code_word_out       = codeWord_q;
  assign bus.data1_plus_imm8_out = d1PlusImm8_q;
  assign bus.waiting_global      = (state_q != ST_RUN);

endmodule

// File: tb/tb_processor_stage2_gen.sv
// tb_processor_stage2_gen
// Scoreboard bench for processor_stage2_gen: a register-file model answers
// the read ports, expected stage-3 results are queued when words are driven
// and compared when the stage presents them.

module tb_processor_stage2_gen;
  import processor_pkg::*;

  localparam int AW = 18;
  localparam int WW = 18;
  localparam int RB = 3;

  logic clock = 1'b0;
  logic reset;
  int   testsRun    = 0;
  int   testsFailed = 0;

  typedef struct packed {
    logic [WW-1:0] d0;
    logic [WW-1:0] d1;
    logic [WW-1:0] code;
    logic [AW-1:0] d1pi;
  } expOut_t;

  expOut_t       sbQueue[$];
  expOut_t       monExp;
  logic [WW-1:0] regFile [8];
  logic [RB-1:0] preAddr [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd7};
  logic [WW-1:0] preData [5] = '{18'h0, 18'h7, 18'h100, 18'h55, 18'h3FFF0};
  logic [WW-1:0] stallWord;

  processor_stage2_gen_if #(.ADDR_SIZE(AW), .WORD_SIZE(WW), .REG_ADDR_BITS(RB)) bus ();

`ifdef PROCESSOR_DEBUG_INTERFACE_EN
  logic          debugGetParam = 1'b0;
  logic [RB:0]   debugRegAddr  = '0;
  logic [WW-1:0] debugDataOut;
`endif

  processor_stage2_gen #(.ADDR_SIZE(AW), .WORD_SIZE(WW), .REG_ADDR_BITS(RB)) dut (
    .clock           (clock),
    .reset           (reset),
`ifdef PROCESSOR_DEBUG_INTERFACE_EN
    .debug_get_param (debugGetParam),
    .debug_reg_addr  (debugRegAddr),
    .debug_data_out  (debugDataOut),
`endif
    .bus             (bus)
  );

  always #5 clock = ~clock;

  // Register file model: combinational reads, writeback on the clock edge
  always_comb begin
    bus.reg_read_data0 = regFile[bus.reg_read_addr0];
    bus.reg_read_data1 = regFile[bus.reg_read_addr1];
  end

  always @(posedge clock) begin
    if (bus.writeback_reg_write_enable)
      regFile[bus.writeback_reg_write_addr] <= bus.writeback_reg_write_data;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [WW-1:0] enc(input logic [3:0] op, input logic [RB-1:0] rx,
                                        input logic [RB-1:0] ry, input logic [7:0] imm);
    return {op, rx, ry, imm};
  endfunction

  // Scoreboard consumer: every presented result is compared with the oldest
  // expectation; it is retired only when stage 3 takes it
  always @(negedge clock) begin
    if (reset === 1'b1 && bus.out_valid === 1'b1) begin
      if (sbQueue.size() == 0) begin
        checkOutput("unexpectedOutValid", 32'd1, 32'd0);
      end else begin
        monExp = sbQueue[0];
        checkOutput("aluData0Out", 32'(bus.alu_data0_out), 32'(monExp.d0));
        checkOutput("aluData1Out", 32'(bus.alu_data1_out), 32'(monExp.d1));
        checkOutput("codeWordOut", 32'(bus.code_word_out), 32'(monExp.code));
        checkOutput("data1PlusImm8Out", 32'(bus.data1_plus_imm8_out), 32'(monExp.d1pi));
        if (bus.out_ready) void'(sbQueue.pop_front());
      end
    end
  end

  // Drives one word for one cycle starting just after a rising edge,
  // checks the same-cycle side effects and queues the expected result
  task automatic applyStimulus(input logic [WW-1:0] word, input logic [AW-1:0] ipVal,
                               input logic expWe, input logic [AW-1:0] expAddr,
                               input logic [WW-1:0] expMemIn, input logic expCall,
                               input logic [AW-1:0] expTarget, input logic expValid,
                               input logic [WW-1:0] expD0, input logic [WW-1:0] expD1,
                               input logic [AW-1:0] expD1pi);
    bus.in_valid    = 1'b1;
    bus.code_word   = word;
    bus.ip          = ipVal;
    bus.ip_plus_one = ipVal + 18'd1;
    @(negedge clock);
    checkOutput("inReady", 32'(bus.in_ready), 32'd1);
    checkOutput("memWriteEnable", 32'(bus.memory_write_enable), 32'(expWe));
    if (expWe) begin
      checkOutput("memoryAddr", 32'(bus.memory_addr), 32'(expAddr));
      checkOutput("memoryIn", 32'(bus.memory_in), 32'(expMemIn));
    end
    checkOutput("callPerformed", 32'(bus.call_performed), 32'(expCall));
    if (expCall) checkOutput("ipToCall", 32'(bus.ip_to_call), 32'(expTarget));
    #1;
    if (expValid) sbQueue.push_back('{expD0, expD1, word, expD1pi});
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic checkWaiting(input string tag, input logic expWaiting);
    @(negedge clock);
    checkOutput({tag, "Waiting"}, 32'(bus.waiting_global), 32'(expWaiting));
    checkOutput({tag, "InReady"}, 32'(bus.in_ready), 32'(!expWaiting));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset                          = 1'b0;
    bus.in_valid                   = 1'b0;
    bus.code_word                  = '0;
    bus.ip                         = '0;
    bus.ip_plus_one                = '0;
    bus.writeback_reg_write_enable = 1'b0;
    bus.writeback_reg_write_addr   = '0;
    bus.writeback_reg_write_data   = '0;
    bus.out_ready                  = 1'b1;
    bus.wait_resume                = 1'b0;

    // Preload registers through the writeback port while held in reset
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      bus.writeback_reg_write_enable = 1'b1;
      bus.writeback_reg_write_addr   = preAddr[i];
      bus.writeback_reg_write_data   = preData[i];
    end
    @(posedge clock);
    #1;
    bus.writeback_reg_write_enable = 1'b0;

    @(negedge clock);
    checkOutput("rstOutValid", 32'(bus.out_valid), 32'd0);
    checkOutput("rstReturn", 32'(bus.return_performed), 32'd0);
    checkOutput("rstWaiting", 32'(bus.waiting_global), 32'd0);
    checkOutput("rstAluData0", 32'(bus.alu_data0_out), 32'd0);
    checkOutput("rstAluData1", 32'(bus.alu_data1_out), 32'd0);
    checkOutput("rstCodeWord", 32'(bus.code_word_out), 32'd0);
    @(posedge clock);
    #2;
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Store: r3 to r2 + sext(0xFE)
    applyStimulus(enc(OP_WRITE_TO_MEMORY, 3'd3, 3'd2, 8'hFE), 18'h20,
                  1'b1, 18'h000FE, 18'h55, 1'b0, 18'h0, 1'b1, 18'h55, 18'h100, 18'h000FE);

    // Bypass: r2 written back in the same cycle it is read
    bus.writeback_reg_write_enable = 1'b1;
    bus.writeback_reg_write_addr   = 3'd2;
    bus.writeback_reg_write_data   = 18'h200;
    applyStimulus(enc(OP_ADD, 3'd1, 3'd2, 8'h04), 18'h21,
                  1'b0, 18'h0, 18'h0, 1'b0, 18'h0, 1'b1, 18'h7, 18'h200, 18'h204);
    bus.writeback_reg_write_enable = 1'b0;

    // Taken branch: r0 == 0, negative offset, data1 replaced by ip
    applyStimulus(enc(OP_IF, 3'd0, IF_ZERO, 8'hF0), 18'h40,
                  1'b0, 18'h0, 18'h0, 1'b1, 18'h30, 1'b1, 18'h0, 18'h40, 18'h3FFF7);

    // Untaken branch: r1 != 0
    applyStimulus(enc(OP_IF, 3'd1, IF_ZERO, 8'h05), 18'h50,
                  1'b0, 18'h0, 18'h0, 1'b0, 18'h0, 1'b1, 18'h7, 18'h7, 18'h0000C);

    // Call: push ip+1 at sp, jump to imm14
    applyStimulus({OP_CALL_IMM14, 14'h0123}, 18'h10,
                  1'b1, 18'h3FFF0, 18'h11, 1'b1, 18'h123, 1'b1, 18'h0, 18'h3FFF0, 18'h00013);

    // Return: one-cycle registered pulse after acceptance
    applyStimulus(enc(OP_RETURN, 3'd0, 3'd0, 8'h00), 18'h60,
                  1'b0, 18'h0, 18'h0, 1'b0, 18'h0, 1'b1, 18'h0, 18'h0, 18'h0);
    @(negedge clock);
    checkOutput("returnPulse", 32'(bus.return_performed), 32'd1);
    @(negedge clock);
    checkOutput("returnPulseEnd", 32'(bus.return_performed), 32'd0);
    @(posedge clock);
    #1;

    // Counted wait of 3 cycles; a pending word must not be taken meanwhile
    applyStimulus(enc(OP_WAIT, 3'd0, 3'd0, 8'd3), 18'h70,
                  1'b0, 18'h0, 18'h0, 1'b0, 18'h0, 1'b0, 18'h0, 18'h0, 18'h0);
    bus.in_valid  = 1'b1;
    bus.code_word = enc(OP_ADD, 3'd1, 3'd1, 8'h00);
    for (int i = 0; i < 3; i++) begin
      checkWaiting("cntWait", 1'b1);
      checkOutput("cntWaitOutValid", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    checkWaiting("cntWaitDone", 1'b0);
    @(posedge clock);
    #1;

    // wait_resume has no effect while running
    bus.wait_resume = 1'b1;
    checkWaiting("resumeInRun", 1'b0);
    @(posedge clock);
    #1;
    bus.wait_resume = 1'b0;

    // Halt, then resume one cycle after wait_resume
    applyStimulus(enc(OP_WAIT, 3'd0, 3'd0, 8'd0), 18'h80,
                  1'b0, 18'h0, 18'h0, 1'b0, 18'h0, 1'b0, 18'h0, 18'h0, 18'h0);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) checkWaiting("halt", 1'b1);
    @(posedge clock);
    #1;
    bus.wait_resume = 1'b1;
    checkWaiting("haltResumeCycle", 1'b1);
    @(posedge clock);
    #1;
    bus.wait_resume = 1'b0;
    bus.in_valid    = 1'b0;
    checkWaiting("haltResumed", 1'b0);
    @(posedge clock);
    #1;

    // Reset mid-halt returns to run immediately, without a clock edge
    applyStimulus(enc(OP_WAIT, 3'd0, 3'd0, 8'd0), 18'h88,
                  1'b0, 18'h0, 18'h0, 1'b0, 18'h0, 1'b0, 18'h0, 18'h0, 18'h0);
    checkWaiting("haltBeforeReset", 1'b1);
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("resetAbortWaiting", 32'(bus.waiting_global), 32'd0);
    checkOutput("resetAbortInReady", 32'(bus.in_ready), 32'd1);
    checkOutput("resetAbortCodeWord", 32'(bus.code_word_out), 32'd0);
    @(posedge clock);
    #2;
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Stall: stage 3 refuses for 4 cycles while a store is pending
    applyStimulus(enc(OP_ADD, 3'd1, 3'd3, 8'h10), 18'h90,
                  1'b0, 18'h0, 18'h0, 1'b0, 18'h0, 1'b1, 18'h7, 18'h55, 18'h65);
    stallWord       = enc(OP_WRITE_TO_MEMORY, 3'd3, 3'd2, 8'h02);
    bus.out_ready   = 1'b0;
    bus.in_valid    = 1'b1;
    bus.code_word   = stallWord;
    bus.ip          = 18'h91;
    bus.ip_plus_one = 18'h92;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checkOutput("stallInReady", 32'(bus.in_ready), 32'd0);
      checkOutput("stallNoWrite", 32'(bus.memory_write_enable), 32'd0);
      @(posedge clock);
      #1;
    end
    bus.out_ready = 1'b1;
    applyStimulus(stallWord, 18'h91,
                  1'b1, 18'h202, 18'h55, 1'b0, 18'h0, 1'b1, 18'h55, 18'h200, 18'h202);

    repeat (3) @(posedge clock);
    #1;
    checkOutput("scoreboardDrained", 32'(sbQueue.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
